// File: rtl/ccm_rr_arbiter.sv
// ccm_rr_arbiter: round-robin arbiter sharing one single-ported CCM array between NREQ requesters
// Ports: clk, rst_l (async, active-high); req_valid/req_ready/req_wr/req_addr/req_wdata per requester;
//        rsp_valid (one-hot), rsp_err, rsp_rdata; mem_en/mem_wr/mem_addr/mem_wdata to SRAM, mem_rdata from SRAM.
// Optional: `define CCM_ARB_LOCK_EN adds req_lock, letting a granted requester keep top priority (max 16 grants).
module ccm_rr_arbiter #(
    parameter int          NREQ     = 4,
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [AW-1:0] CCM_SADR = 32'hF004_0000,
    parameter int          CCM_SIZE = 64,
    parameter int          RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_wr,
`ifdef CCM_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_en,
    output logic               mem_wr,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int IW   = $clog2(NREQ);
    localparam int MASK = 10 + $clog2(CCM_SIZE);

    logic [IW-1:0] rr_ptr, gnt, idx, inc, ptr_d;
    logic          any, g_wr, g_inr, issue;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    // Scan from the highest offset down so the lowest offset after rr_ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
        req_ready      = '0;
        req_ready[gnt] = any;
        g_wr    = req_wr[gnt];
        g_addr  = req_addr[int'(gnt)*AW +: AW];
        g_wdata = req_wdata[int'(gnt)*DW +: DW];
        g_inr   = g_addr[AW-1:MASK] == CCM_SADR[AW-1:MASK];
        // A 48 KB window is the lower three quarters of a 64 KB aligned block.
        if (CCM_SIZE == 48)
            g_inr = g_inr & ~&g_addr[MASK-1:MASK-2];
        issue = any & g_inr;
        inc   = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end

`ifdef CCM_ARB_LOCK_EN
    logic [3:0]    lock_cnt, prior, cnt_d;
    logic [IW-1:0] lock_id;
    logic          keep;

    // lock_cnt counts earlier consecutive locked grants to lock_id; the 16th forces rotation.
    always_comb begin
        prior = (lock_id == gnt) ? lock_cnt : 4'd0;
        keep  = req_lock[gnt] && prior != 4'd15;
        ptr_d = keep ? gnt : inc;
        cnt_d = keep ? prior + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            lock_cnt <= '0;
            lock_id  <= '0;
        end else if (any) begin
            lock_cnt <= cnt_d;
            lock_id  <= gnt;
        end
    end
`else
    assign ptr_d = inc;
`endif

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l)
            rr_ptr <= '0;
        else if (any)
            rr_ptr <= ptr_d;
    end

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= issue;
            mem_wr    <= issue & g_wr;
            mem_addr  <= issue ? g_addr : '0;
            mem_wdata <= (issue & g_wr) ? g_wdata : '0;
        end
    end

    // Tag stage RD_LAT lines up with the cycle the SRAM returns read data.
    logic [RD_LAT:0] tv, te, tw;
    logic [IW-1:0]   tid [RD_LAT+1];

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            tv <= '0;
            te <= '0;
            tw <= '0;
            for (int k = 0; k <= RD_LAT; k++)
                tid[k] <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            tv     <= {tv[RD_LAT-1:0], any};
            te     <= {te[RD_LAT-1:0], ~g_inr};
            tw     <= {tw[RD_LAT-1:0], g_wr};
            tid[0] <= gnt;
            for (int k = 1; k <= RD_LAT; k++)
                tid[k] <= tid[k-1];
            rsp_valid <= tv[RD_LAT] ? (NREQ'(1) << tid[RD_LAT]) : '0;
            rsp_err   <= tv[RD_LAT] & te[RD_LAT];
            rsp_rdata <= (tv[RD_LAT] & ~te[RD_LAT] & ~tw[RD_LAT]) ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_ccm_rr_arbiter.sv
// tb_ccm_rr_arbiter: directed, table-driven bench for ccm_rr_arbiter
module tb_ccm_rr_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_l;
    logic [3:0]   req_valid, req_ready, req_wr, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic         rsp_err, mem_en, mem_wr;
    logic [31:0]  rsp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef CCM_ARB_LOCK_EN
    logic [3:0]   req_lock;
`endif

    logic [3:0]   valid_b, ready_b, wr_b, rsp_valid_b;
    logic [127:0] addr_b, wdata_b;
    logic         rsp_err_b, mem_en_b, mem_wr_b;
    logic [31:0]  rsp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
`ifdef CCM_ARB_LOCK_EN
    logic [3:0]   lock_b;
`endif

    ccm_rr_arbiter dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
`ifdef CCM_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    ccm_rr_arbiter #(.CCM_SADR(32'hF000_0000), .CCM_SIZE(48)) u48 (
        .clk(clk), .rst_l(rst_l),
        .req_valid(valid_b), .req_ready(ready_b), .req_wr(wr_b),
`ifdef CCM_ARB_LOCK_EN
        .req_lock(lock_b),
`endif
        .req_addr(addr_b), .req_wdata(wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
        .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // Grant sequence hand-derived from rr_ptr=0 after reset.
        tbl = '{
            '{4'b0000, 4'b0000}, '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010},
            '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001},
            '{4'b0001, 4'b0001}, '{4'b1001, 4'b1000}, '{4'b0110, 4'b0010},
            '{4'b0000, 4'b0000}, '{4'b0011, 4'b0001}, '{4'b0101, 4'b0100},
            '{4'b0111, 4'b0001}, '{4'b0100, 4'b0100}, '{4'b1000, 4'b1000},
            '{4'b0000, 4'b0000}, '{4'b0000, 4'b0000}, '{4'b0000, 4'b0000}
        };
        rst_l = 1'b1;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
        valid_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0; mem_rdata_b = '0;
`ifdef CCM_ARB_LOCK_EN
        req_lock = '0; lock_b = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        tick();
        rst_l = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_wr", mem_wr, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_rsp_err", rsp_err, 0);
        chk("idle_rsp_rdata", rsp_rdata, 0);

        for (int i = 0; i < 4; i++)
            req_addr[i*32 +: 32] = 32'hF004_0000 + 32'(i * 16);
        mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 18; i++) begin
            tick();
            req_valid = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("tbl_ready[%0d]", i), req_ready, tbl[i].ready);
            if (i >= 1)
                chk($sformatf("tbl_mem_en[%0d]", i), mem_en, |tbl[i-1].ready);
            if (i >= 3)
                chk($sformatf("tbl_rsp_valid[%0d]", i), rsp_valid, tbl[i-3].ready);
        end

        // Single in-range read from requester 0 (rr_ptr=0 here).
        tick();
        mem_rdata = '0;
        req_addr[31:0] = 32'hF004_0010;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("rd_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_wr", mem_wr, 0);
        chk("rd_mem_addr", mem_addr, 32'hF004_0010);
        chk("rd_mem_wdata", mem_wdata, 0);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_rsp_early", rsp_valid, 0);
        tick();
        mem_rdata = '0;
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 4'b0001);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);
        tick();
        @(negedge clk);
        chk("rd_rsp_once", rsp_valid, 0);

        // Out-of-range write from requester 2 (rr_ptr=1).
        tick();
        req_wr = 4'b0100;
        req_addr[95:64] = 32'h0000_1000;
        req_wdata[95:64] = 32'h1234_5678;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("oor_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        req_wr = '0;
        @(negedge clk);
        chk("oor_mem_en", mem_en, 0);
        chk("oor_mem_wr", mem_wr, 0);
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        chk("oor_rsp_valid", rsp_valid, 4'b0100);
        chk("oor_rsp_err", rsp_err, 1);
        chk("oor_rsp_rdata", rsp_rdata, 0);
        mem_rdata = '0;

        // In-range write from requester 3 (rr_ptr=3).
        tick();
        req_wr = 4'b1000;
        req_addr[127:96] = 32'hF004_0100;
        req_wdata[127:96] = 32'hA5A5_A5A5;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("wr_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        req_wr = '0;
        @(negedge clk);
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_wr", mem_wr, 1);
        chk("wr_mem_addr", mem_addr, 32'hF004_0100);
        chk("wr_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        tick();
        mem_rdata = 32'hCAFE_F00D;
        tick();
        @(negedge clk);
        chk("wr_rsp_valid", rsp_valid, 4'b1000);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        mem_rdata = '0;

        // 48 KB window: top quarter of the 64 KB block is out of range.
        tick();
        addr_b[31:0] = 32'hF000_C000;
        valid_b = 4'b0001;
        @(negedge clk);
        chk("w48_ready", ready_b, 4'b0001);
        tick();
        addr_b[31:0] = 32'hF000_BFFC;
        @(negedge clk);
        chk("w48_ready2", ready_b, 4'b0001);
        chk("w48_hole_mem_en", mem_en_b, 0);
        tick();
        valid_b = '0;
        @(negedge clk);
        chk("w48_ok_mem_en", mem_en_b, 1);
        chk("w48_ok_mem_addr", mem_addr_b, 32'hF000_BFFC);
        tick();
        @(negedge clk);
        chk("w48_hole_rsp", rsp_valid_b, 4'b0001);
        chk("w48_hole_err", rsp_err_b, 1);
        tick();
        @(negedge clk);
        chk("w48_ok_rsp", rsp_valid_b, 4'b0001);
        chk("w48_ok_err", rsp_err_b, 0);

        // Reset the cycle after a handshake: its response must never appear.
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rst_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        rst_l = 1'b1;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        tick();
        rst_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_rsp[%0d]", i), rsp_valid, 0);
            tick();
        end

`ifdef CCM_ARB_LOCK_EN
        // Locked requester 1 holds priority for 16 grants, then rotation resumes.
        req_lock = 4'b0010;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("lock_first", req_ready, 4'b0001);
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("lock_hold[%0d]", i), req_ready, 4'b0010);
        end
        tick();
        @(negedge clk);
        chk("lock_rotate", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        req_lock = '0;
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
